// File: rtl/mi32_arb_pkg.sv
// mi32_arb_pkg: shared state type, sizes and one-hot encoder for the mi32 arbiters
package mi32_arb_pkg;
  localparam int NREQ = 5;
  localparam int ID_W = 3;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_GAP = 2'd2} state_t;
  // one-hot to binary index; all-zero input maps to 0
  function automatic logic [ID_W-1:0] encode(input logic [NREQ-1:0] oh);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < NREQ; i++) if (oh[i]) id = id | ID_W'(i);
    return id;
  endfunction
endpackage

// File: rtl/mi32_arb_if.sv
// mi32_arb_if: request/grant bundle between the DMA channels, the sink and the arbiter
interface mi32_arb_if;
  import mi32_arb_pkg::*;
  logic [NREQ-1:0] req;
  logic            ack;
  logic            last;
  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gnt_id;
  logic            busy;
  logic            abort;
  modport master (input req, ack, last, output gnt, gnt_id, busy, abort);
  modport slave  (output req, ack, last, input gnt, gnt_id, busy, abort);
endinterface

// File: rtl/mi32_arb_rr_pick5.sv
// rr_pick5: combinational round-robin pick over 5 requests, searching upward from ptr+1
module rr_pick5 (
  input  logic [4:0] i_req,
  input  logic [2:0] i_ptr,
  output logic [4:0] o_winner
);
  logic [2:0] w_start;
  logic [4:0] w_rot;
  logic [4:0] w_first;
  // rotate so the search start sits at bit 0, isolate the lowest set bit, rotate back
  always_comb begin
    w_start  = (i_ptr >= 3'd4) ? 3'd0 : i_ptr + 3'd1;
    w_rot    = 5'({i_req, i_req} >> w_start);
    w_first  = w_rot & (~w_rot + 5'd1);
    o_winner = 5'(({w_first, w_first} << w_start) >> 5);
  end
endmodule

// File: rtl/mi32_arb.sv
// mi32_arb: round-robin burst arbiter with beat limit and one idle GAP state between owners
// Optional: define MI32_ARB_PRIO0_EN to give channel 0 strict priority in IDLE.
module mi32_arb
  import mi32_arb_pkg::*;
#(
  parameter int NREQ      = 5,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 8
) (
  input logic        clk,
  input logic        rst_n,
  mi32_arb_if.master bus
);
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_ptr, w_ptr_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt, w_pick, w_win;
  logic             r_abort, w_abort_nxt;
  logic             w_ptr_upd, w_own, w_fin, w_lim, w_rel;

  rr_pick5 u_pick (.i_req(bus.req), .i_ptr(r_ptr), .o_winner(w_pick));

`ifdef MI32_ARB_PRIO0_EN
  assign w_win     = bus.req[0] ? NREQ'(1) : w_pick;
  assign w_ptr_upd = !bus.req[0];
`else
  assign w_win     = w_pick;
  assign w_ptr_upd = 1'b1;
`endif

  assign w_own = |(bus.req & r_gnt);
  assign w_fin = bus.ack & bus.last;
  assign w_lim = bus.ack && (r_cnt == CNT_W'(MAX_BEATS - 1));
  assign w_rel = w_fin | w_lim | ~w_own;

  // next-state: grant in IDLE, count beats and release in BUSY, one forced idle cycle in GAP
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_abort_nxt = 1'b0;
    case (r_state)
      ST_IDLE: if (|bus.req) begin
        w_state_nxt = ST_BUSY;
        w_gnt_nxt   = w_win;
        w_cnt_nxt   = '0;
        w_ptr_nxt   = w_ptr_upd ? encode(w_win) : r_ptr;
      end
      ST_BUSY: if (w_rel) begin
        w_state_nxt = ST_GAP;
        w_gnt_nxt   = '0;
        w_cnt_nxt   = '0;
        w_abort_nxt = ~w_own & ~w_fin;
      end else begin
        w_cnt_nxt   = r_cnt + CNT_W'(bus.ack);
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // state, counter, pointer and registered outputs; ptr resets to 4 so channel 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ptr   <= 3'd4;
      r_gnt   <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.gnt_id = encode(r_gnt);
  assign bus.busy   = |r_gnt;
  assign bus.abort  = r_abort;
endmodule
